// File: rtl/output_sram_arbiter.sv
// Round-robin arbiter that grants one bank buffer at a time the shared output
// SRAM write port and turns its sos..eos beat stream into addressed writes.
module output_sram_arbiter #(
  parameter int NUM_BANKS  = 4,
  parameter int FV_W       = 16,
  parameter int NODE_W     = 8,
  parameter int MAX_FV_NUM = 16,
  parameter int ADDR_W     = 12,
  parameter int TIMEOUT    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_BANKS-1:0]        bank_req,
  output logic [NUM_BANKS-1:0]        bank_grant,
  input  logic [NUM_BANKS-1:0]        bank_valid,
  input  logic [NUM_BANKS-1:0]        bank_sos,
  input  logic [NUM_BANKS-1:0]        bank_eos,
  input  logic [NUM_BANKS*2*FV_W-1:0] bank_data,
  input  logic [NUM_BANKS*NODE_W-1:0] bank_nodeid,
  output logic                        sram_wen,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [2*FV_W-1:0]           sram_wdata,
  output logic                        busy,
  output logic                        err_timeout,
  output logic                        err_overrun
);
  localparam int BEATS = MAX_FV_NUM / 2;
  localparam int BW    = 2 * FV_W;
  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PW    = ADDR_W + NODE_W;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_SOS, STREAM} state_t;

  state_t                              state;
  logic [IDX_W-1:0]                    owner, rr_ptr, pick, cand;
  logic                                pick_vld;
  logic [CNT_W-1:0]                    beat_cnt;
  logic [TMR_W-1:0]                    timer;
  logic [NODE_W-1:0]                   nodeid_q;
  logic [NUM_BANKS-1:0][BW-1:0]        data_arr;
  logic [NUM_BANKS-1:0][NODE_W-1:0]    nid_arr;
  logic                                o_valid, o_sos, o_eos;
  logic [BW-1:0]                       o_data;
  logic [NODE_W-1:0]                   o_nid;

  assign data_arr = bank_data;
  assign nid_arr  = bank_nodeid;
  // Only the owner's beat inputs ever reach the datapath.
  assign o_valid  = bank_valid[owner];
  assign o_sos    = bank_sos[owner];
  assign o_eos    = bank_eos[owner];
  assign o_data   = data_arr[owner];
  assign o_nid    = nid_arr[owner];
  assign busy     = (state != IDLE);

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_BANKS);
      if (!pick_vld && bank_req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [NODE_W-1:0] nid,
                                                  input logic [CNT_W-1:0]  idx);
    logic [PW-1:0] a;
    a = PW'(nid) * PW'(BEATS) + PW'(idx);
    return a[ADDR_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      timer       <= '0;
      nodeid_q    <= '0;
      bank_grant  <= '0;
      sram_wen    <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      bank_grant <= '0;
      sram_wen   <= 1'b0;
      case (state)
        IDLE: if (pick_vld) begin
          owner      <= pick;
          rr_ptr     <= (pick == IDX_W'(NUM_BANKS - 1)) ? '0 : pick + IDX_W'(1);
          bank_grant <= NUM_BANKS'(1) << pick;
          state      <= GRANT;
        end
        GRANT: begin
          timer <= '0;
          state <= WAIT_SOS;
        end
        WAIT_SOS: begin
          if (o_valid && o_sos) begin
            nodeid_q   <= o_nid;
            sram_wen   <= 1'b1;
            sram_addr  <= beat_addr(o_nid, CNT_W'(0));
            sram_wdata <= o_data;
            beat_cnt   <= CNT_W'(1);
            state      <= o_eos ? IDLE : STREAM;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        STREAM: if (o_valid) begin
          // A beat beyond the node's slot is dropped rather than spilling into the next node.
          if (beat_cnt == CNT_W'(BEATS)) begin
            err_overrun <= 1'b1;
            state       <= IDLE;
          end else begin
            sram_wen   <= 1'b1;
            sram_addr  <= beat_addr(nodeid_q, beat_cnt);
            sram_wdata <= o_data;
            beat_cnt   <= beat_cnt + CNT_W'(1);
            if (o_eos) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_sram_arbiter.sv
// Directed bench for output_sram_arbiter: grants, write addressing, round-robin,
// timeout/overrun errors, non-owner isolation and mid-stream reset.
module tb_output_sram_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   bank_req, bank_grant, bank_valid, bank_sos, bank_eos;
  logic [127:0] bank_data;
  logic [31:0]  bank_nodeid;
  logic         sram_wen;
  logic [11:0]  sram_addr;
  logic [31:0]  sram_wdata;
  logic         busy, err_timeout, err_overrun;
  int           checks = 0;
  int           passes = 0;

  output_sram_arbiter #(.NUM_BANKS(4), .FV_W(16), .NODE_W(8), .MAX_FV_NUM(16),
                        .ADDR_W(12), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .bank_req(bank_req), .bank_grant(bank_grant),
    .bank_valid(bank_valid), .bank_sos(bank_sos), .bank_eos(bank_eos),
    .bank_data(bank_data), .bank_nodeid(bank_nodeid), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .busy(busy),
    .err_timeout(err_timeout), .err_overrun(err_overrun));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    bank_valid = '0;
    bank_sos   = '0;
    bank_eos   = '0;
  endtask

  task automatic drive(input int b, input logic s, input logic e, input logic [31:0] d);
    bank_valid[b]       = 1'b1;
    bank_sos[b]         = s;
    bank_eos[b]         = e;
    bank_data[b*32+:32] = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bank_req = '0; bank_data = '0; bank_nodeid = '0;
    clear_beats();
    tick(); tick();
    checks++;
    if ({bank_grant, sram_wen, sram_addr, sram_wdata, busy, err_timeout, err_overrun} !== 52'd0)
      $display("FAIL reset_outputs got grant=%b wen=%b addr=%0d wdata=%h busy=%b et=%b eo=%b exp all 0",
               bank_grant, sram_wen, sram_addr, sram_wdata, busy, err_timeout, err_overrun);
    else passes++;
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, bank_grant} !== 5'd0) $display("FAIL reset_idle got busy=%b grant=%b exp 0", busy, bank_grant);
    else passes++;
  endtask

  task automatic test_single_stream();
    logic [31:0] d;
    bank_nodeid[2*8+:8] = 8'd5;
    bank_req[2] = 1'b1;
    tick();
    checks++;
    if ({bank_grant, busy} !== 5'b0100_1) $display("FAIL t1_grant got grant=%b busy=%b exp 0100 1", bank_grant, busy);
    else passes++;
    bank_req[2] = 1'b0;
    tick();
    checks++;
    if ({bank_grant, sram_wen} !== 5'd0) $display("FAIL t1_pulse got grant=%b wen=%b exp 0", bank_grant, sram_wen);
    else passes++;
    for (int k = 0; k < 8; k++) begin
      d = {16'(k), 16'(k)};
      clear_beats();
      drive(2, k == 0, k == 7, d);
      tick();
      checks++;
      if ({bank_grant, sram_wen, sram_addr, sram_wdata} !== {4'b0, 1'b1, 12'(40 + k), d})
        $display("FAIL t1_write%0d got grant=%b wen=%b addr=%0d wdata=%h exp 0 1 %0d %h",
                 k, bank_grant, sram_wen, sram_addr, sram_wdata, 40 + k, d);
      else passes++;
    end
    clear_beats();
    checks++;
    if (busy !== 1'b0) $display("FAIL t1_busy_drop got %b exp 0", busy);
    else passes++;
    tick();
    checks++;
    if (sram_wen !== 1'b0) $display("FAIL t1_no_extra_write got %b exp 0", sram_wen);
    else passes++;
  endtask

  task automatic test_round_robin();
    int e;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int b = 0; b < 4; b++) bank_nodeid[b*8+:8] = 8'(b + 1);
    bank_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      e = g % 4;
      tick();
      checks++;
      if (bank_grant !== 4'(1 << e)) $display("FAIL rr_grant%0d got %b exp %b", g, bank_grant, 4'(1 << e));
      else passes++;
      tick();
      checks++;
      if ({bank_grant, sram_wen} !== 5'd0) $display("FAIL rr_gap%0d got grant=%b wen=%b exp 0", g, bank_grant, sram_wen);
      else passes++;
      clear_beats();
      drive(e, 1'b1, 1'b0, 32'(g * 2));
      tick();
      checks++;
      if ({sram_wen, sram_addr, sram_wdata} !== {1'b1, 12'((e + 1) * 8), 32'(g * 2)})
        $display("FAIL rr_beat0_%0d got wen=%b addr=%0d wdata=%h exp 1 %0d %h",
                 g, sram_wen, sram_addr, sram_wdata, (e + 1) * 8, g * 2);
      else passes++;
      clear_beats();
      drive(e, 1'b0, 1'b1, 32'(g * 2 + 1));
      tick();
      checks++;
      if ({sram_wen, sram_addr, sram_wdata, busy} !== {1'b1, 12'((e + 1) * 8 + 1), 32'(g * 2 + 1), 1'b0})
        $display("FAIL rr_beat1_%0d got wen=%b addr=%0d wdata=%h busy=%b exp 1 %0d %h 0",
                 g, sram_wen, sram_addr, sram_wdata, busy, (e + 1) * 8 + 1, g * 2 + 1);
      else passes++;
      clear_beats();
      if (g == 4) bank_req = '0;
    end
    tick();
    checks++;
    if (bank_grant !== 4'b0) $display("FAIL rr_quiet got %b exp 0000", bank_grant);
    else passes++;
  endtask

  task automatic test_single_beat();
    bank_nodeid[3*8+:8] = 8'd3;
    bank_req = 4'b1000;
    tick();
    checks++;
    if (bank_grant !== 4'b1000) $display("FAIL sb_grant got %b exp 1000", bank_grant);
    else passes++;
    bank_req = '0;
    tick();
    drive(3, 1'b1, 1'b1, 32'hBEEF_0003);
    tick();
    checks++;
    if ({sram_wen, sram_addr, sram_wdata, busy} !== {1'b1, 12'd24, 32'hBEEF_0003, 1'b0})
      $display("FAIL sb_write got wen=%b addr=%0d wdata=%h busy=%b exp 1 24 beef0003 0",
               sram_wen, sram_addr, sram_wdata, busy);
    else passes++;
    clear_beats();
    bank_req = 4'b0110;
    tick();
    checks++;
    if (bank_grant !== 4'b0010) $display("FAIL sb_next_grant got %b exp 0010", bank_grant);
    else passes++;
    bank_req[1] = 1'b0;
  endtask

  task automatic test_timeout();
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({sram_wen, busy, err_timeout} !== 3'b010)
        $display("FAIL to_wait%0d got wen=%b busy=%b et=%b exp 0 1 0", i, sram_wen, busy, err_timeout);
      else passes++;
    end
    tick();
    checks++;
    if ({sram_wen, busy, err_timeout} !== 3'b001)
      $display("FAIL to_expire got wen=%b busy=%b et=%b exp 0 0 1", sram_wen, busy, err_timeout);
    else passes++;
    tick();
    checks++;
    if (bank_grant !== 4'b0100) $display("FAIL to_pending_grant got %b exp 0100", bank_grant);
    else passes++;
    bank_req = '0;
  endtask

  task automatic test_overrun();
    bank_nodeid[2*8+:8] = 8'd0;
    tick();
    for (int k = 0; k < 9; k++) begin
      clear_beats();
      drive(2, k == 0, 1'b0, 32'(k + 32'h50));
      tick();
      checks++;
      if (k < 8) begin
        if ({sram_wen, sram_addr, sram_wdata, err_overrun} !== {1'b1, 12'(k), 32'(k + 32'h50), 1'b0})
          $display("FAIL ov_write%0d got wen=%b addr=%0d wdata=%h eo=%b exp 1 %0d %h 0",
                   k, sram_wen, sram_addr, sram_wdata, err_overrun, k, k + 32'h50);
        else passes++;
      end else begin
        if ({sram_wen, err_overrun, busy, err_timeout} !== 4'b0101)
          $display("FAIL ov_drop got wen=%b eo=%b busy=%b et=%b exp 0 1 0 1",
                   sram_wen, err_overrun, busy, err_timeout);
        else passes++;
      end
    end
    clear_beats();
    tick();
    checks++;
    if ({sram_wen, err_overrun} !== 2'b01) $display("FAIL ov_sticky got wen=%b eo=%b exp 0 1", sram_wen, err_overrun);
    else passes++;
  endtask

  task automatic test_interference_reset();
    bank_nodeid[0*8+:8] = 8'd7;
    bank_nodeid[1*8+:8] = 8'd9;
    bank_req = 4'b0001;
    tick();
    checks++;
    if (bank_grant !== 4'b0001) $display("FAIL ir_grant got %b exp 0001", bank_grant);
    else passes++;
    bank_req = '0;
    tick();
    drive(0, 1'b1, 1'b0, 32'hA0);
    drive(1, 1'b1, 1'b1, 32'hB0);
    tick();
    checks++;
    if ({sram_wen, sram_addr, sram_wdata} !== {1'b1, 12'd56, 32'hA0})
      $display("FAIL ir_beat0 got wen=%b addr=%0d wdata=%h exp 1 56 a0", sram_wen, sram_addr, sram_wdata);
    else passes++;
    clear_beats();
    drive(3, 1'b1, 1'b1, 32'hC0);
    tick();
    checks++;
    if ({sram_wen, busy} !== 2'b01) $display("FAIL ir_bubble got wen=%b busy=%b exp 0 1", sram_wen, busy);
    else passes++;
    clear_beats();
    drive(0, 1'b0, 1'b0, 32'hA1);
    drive(1, 1'b1, 1'b0, 32'hB1);
    drive(3, 1'b0, 1'b1, 32'hC1);
    tick();
    checks++;
    if ({sram_wen, sram_addr, sram_wdata, busy} !== {1'b1, 12'd57, 32'hA1, 1'b1})
      $display("FAIL ir_beat1 got wen=%b addr=%0d wdata=%h busy=%b exp 1 57 a1 1",
               sram_wen, sram_addr, sram_wdata, busy);
    else passes++;
    clear_beats();
    drive(0, 1'b0, 1'b0, 32'hA2);
    reset = 1'b0;
    tick();
    checks++;
    if ({bank_grant, sram_wen, sram_addr, sram_wdata, busy, err_timeout, err_overrun} !== 52'd0)
      $display("FAIL ir_reset got grant=%b wen=%b addr=%0d wdata=%h busy=%b et=%b eo=%b exp all 0",
               bank_grant, sram_wen, sram_addr, sram_wdata, busy, err_timeout, err_overrun);
    else passes++;
    reset = 1'b1;
    clear_beats();
    bank_req = 4'b1111;
    tick();
    checks++;
    if (bank_grant !== 4'b0001) $display("FAIL ir_rr_reset got %b exp 0001", bank_grant);
    else passes++;
    bank_req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_single_beat();
    test_timeout();
    test_overrun();
    test_interference_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/output_sram_arbiter.md
Name: output_sram_arbiter

Overview:
- Round-robin arbiter and write sequencer for the shared output SRAM port.
- Requesters are the NUM_BANKS per-bank aggregation buffers; each raises a write-back request and waits for a grant.
- The block grants one bank at a time, accepts that bank's sos..eos feature-vector stream, and turns each two-element beat into one SRAM write at an address derived from nodeid.
- It also times out and cleans up after misbehaving streams.

Parameters:
NUM_BANKS, 4, number of requesting bank buffers
FV_W, 16, width of one feature element
NODE_W, 8, nodeid width
MAX_FV_NUM, 16, max feature elements per node (even); beats per node = MAX_FV_NUM/2
ADDR_W, 12, SRAM address width; must be >= NODE_W + clog2(MAX_FV_NUM/2)
TIMEOUT, 8, max cycles from grant to sos

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
bank_req  in  NUM_BANKS  per-bank write-back request, level
bank_grant  out  NUM_BANKS  one-hot single-cycle grant pulse
bank_valid  in  NUM_BANKS  per-bank beat valid (Grant_valid)
bank_sos  in  NUM_BANKS  per-bank start-of-stream
bank_eos  in  NUM_BANKS  per-bank end-of-stream
bank_data  in  NUM_BANKS*2*FV_W  per-bank beat, {data[1],data[0]}, bank 0 in LSBs
bank_nodeid  in  NUM_BANKS*NODE_W  per-bank nodeid, sampled with sos
sram_wen  out  1  SRAM write enable
sram_addr  out  ADDR_W  write address
sram_wdata  out  2*FV_W  write data
busy  out  1  high in any state except IDLE
err_timeout  out  1  sticky: grant not followed by sos within TIMEOUT cycles
err_overrun  out  1  sticky: stream exceeded MAX_FV_NUM/2 beats without eos

Behaviour:
- Reset (reset==0 at a posedge):
  - All outputs 0; state IDLE; rr pointer = 0; beat counter and timer = 0.
  - Reset mid-stream abandons the stream with no further writes.
- States: IDLE, GRANT, WAIT_SOS, STREAM.
- IDLE:
  - If any bank_req bit is high, select the first requesting bank at or after the rr pointer, wrapping modulo NUM_BANKS.
  - Latch the selected index as owner; set rr pointer = owner+1 mod NUM_BANKS; go to GRANT.
  - The request is seen at cycle t; bank_grant[owner]=1 during cycle t+1 only.
- GRANT: assert bank_grant[owner] for exactly one cycle; clear timer; go to WAIT_SOS.
- WAIT_SOS:
  - Only owner's bank_valid/sos/eos/data/nodeid are observed; other banks' beat inputs are ignored in every state.
  - valid&sos from owner: latch nodeid, write beat 0, beat counter=1.
    - If eos is also high (single-beat stream): go to IDLE.
    - Otherwise: go to STREAM.
  - No sos: timer increments. When timer reaches TIMEOUT-1 without sos, set err_timeout and go to IDLE with no write.
- STREAM:
  - Each owner valid beat writes at beat counter, then the counter increments.
  - eos on a beat: write it, then go to IDLE.
  - valid low: no write, hold state (bubbles allowed, no timeout).
  - sos seen again: treat as a normal beat (no restart).
  - If a beat arrives when beat counter == MAX_FV_NUM/2: set err_overrun, drop the beat, go to IDLE.
- Write path:
  - Registered, 1-cycle latency: beat accepted at cycle t gives sram_wen=1 at t+1.
  - sram_addr = nodeid*(MAX_FV_NUM/2) + beat index, truncated to ADDR_W.
  - sram_wdata = owner beat.
  - sram_wen=0 whenever no beat is accepted.
- Turnaround: eos at cycle t gives IDLE at t+1 and the next grant at t+2 at earliest.
- Requests during non-IDLE states: held pending, not lost; a bank's req stays high until it is granted. bank_req of the current owner is ignored until IDLE.
- Fairness: with all banks requesting continuously, grants rotate 0,1,2,3,0,...
- Error flags: sticky until reset.
- busy=1 in GRANT, WAIT_SOS, STREAM.

Test Plan:
1. Single stream: bank 2 req, nodeid=5, 8 beats (sos on 1st, eos on 8th), data=k.
   -> Exactly one grant pulse to bank 2, one cycle after req.
   -> 8 writes at addr 40..47 with wdata k, each one cycle after its beat.
   -> busy drops after eos.
2. Round-robin: all 4 banks req continuously, each sending a 2-beat stream.
   -> Grant order 0,1,2,3,0.
   -> No overlapping writes; grant gap of 2 cycles after each eos.
3. Single-beat stream: sos&eos on the same beat, nodeid=3.
   -> One write at addr 24; return to IDLE; next grant possible 2 cycles later.
4. Timeout: grant bank 1, no sos for 8 cycles.
   -> err_timeout=1, no SRAM write, IDLE.
   -> Bank 2's pending req is granted next.
5. Overrun: 9 beats without eos, nodeid=0.
   -> Writes at addr 0..7; 9th beat dropped; err_overrun=1.
6. Interference and reset: a non-owner bank drives valid/sos mid-stream -> no effect on writes. Assert reset mid-STREAM -> next cycle all outputs 0, rr pointer 0, err flags cleared.
